// File: rtl/uart_rx_byte_if.sv
// Receive-side bundle of uart_rx_byte: serial line in, one-entry byte buffer with ready/read out.
// master is the line driver / byte consumer, slave is the receiver.
interface uart_rx_byte_if;
  logic       uart_rxd;
  logic       read_en;
  logic [7:0] read_data;
  logic       data_ready;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output uart_rxd, read_en,
    input  read_data, data_ready, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    input  uart_rxd, read_en,
    output read_data, data_ready, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM and a one-entry output register
// with ready/read handshake, overrun flag and frame-error pulse.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic           clk_50M,
  input  logic           rst,
  uart_rx_byte_if.slave  rx_if
);

  localparam int unsigned BIT_CLKS  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam int unsigned CNT_W     = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shreg, w_shreg_nxt;
  logic [7:0]       r_read_data, w_read_data_nxt;
  logic             r_data_ready, w_data_ready_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_sync1, r_sync2, r_prev;
  logic             w_fall;

  // r_sync2 is the synchronised line; r_prev is its previous value for edge detect.
  assign w_fall = r_prev & ~r_sync2;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_bit_idx_nxt    = r_bit_idx;
    w_shreg_nxt      = r_shreg;
    w_read_data_nxt  = r_read_data;
    w_data_ready_nxt = r_data_ready;
    w_overrun_nxt    = r_overrun;
    w_rx_valid_nxt   = 1'b0;
    w_frame_err_nxt  = 1'b0;

    if (rx_if.read_en && r_data_ready) begin
      w_data_ready_nxt = 1'b0;
      w_overrun_nxt    = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_state_nxt = StStart;
          w_cnt_nxt   = '0;
        end
      end
      StStart: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_sync2) begin
            w_state_nxt   = StData;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_state_nxt = StIdle;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {r_sync2, r_shreg[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StStop: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
          if (r_sync2) begin
            // Newest byte wins; a simultaneous read consumes the old one, so no overrun.
            w_read_data_nxt  = r_shreg;
            w_data_ready_nxt = 1'b1;
            w_rx_valid_nxt   = 1'b1;
            if (r_data_ready && !rx_if.read_en) begin
              w_overrun_nxt = 1'b1;
            end
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b1;
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shreg      <= 8'h00;
      r_read_data  <= 8'h00;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= rx_if.uart_rxd;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shreg      <= w_shreg_nxt;
      r_read_data  <= w_read_data_nxt;
      r_data_ready <= w_data_ready_nxt;
      r_overrun    <= w_overrun_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign rx_if.read_data  = r_read_data;
  assign rx_if.data_ready = r_data_ready;
  assign rx_if.rx_valid   = r_rx_valid;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.overrun    = r_overrun;
  assign rx_if.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at a scaled-down baud rate (16 clocks per bit).
// Every good frame driven pushes its byte and start time; each rx_valid pops and compares.
module tb_uart_rx_byte;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned BIT      = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = BIT / 2;
  localparam int unsigned LAT      = 2 + HALF + 9 * BIT;

  logic clk;
  logic rst;
  uart_rx_byte_if bus ();

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk_50M (clk),
    .rst     (rst),
    .rx_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;

  logic [7:0]  exp_q[$];
  int unsigned t_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pop the scoreboard on every rx_valid, count frame errors.
  always @(negedge clk) begin
    if (!rst && bus.rx_valid) begin
      n_valid <= n_valid + 1;
      if (exp_q.size() == 0) begin
        check_eq("rx_unexpected_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [7:0]  e;
        int unsigned t;
        int unsigned d;
        e = exp_q.pop_front();
        t = t_q.pop_front();
        d = cyc - t;
        check_eq("rx_data", {24'h0, bus.read_data}, {24'h0, e});
        check_eq("rx_latency_in_window", {31'h0, (d >= LAT && d <= LAT + 2)}, 32'd1);
      end
    end
    if (!rst && bus.frame_err) n_ferr <= n_ferr + 1;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit good);
    @(negedge clk);
    if (good) begin
      exp_q.push_back(b);
      t_q.push_back(cyc);
    end
    bus.uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.uart_rxd = stop;
    repeat (BIT) @(negedge clk);
    bus.uart_rxd = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk);
    bus.read_en = 1'b1;
    @(negedge clk);
    bus.read_en = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq[4];
    logic [7:0] b;
    int         v0, f0;

    seq[0] = 8'h33; seq[1] = 8'hCF; seq[2] = 8'hA2; seq[3] = 8'h45;
    rst          = 1'b1;
    bus.uart_rxd = 1'b1;
    bus.read_en  = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_read_data", {24'h0, bus.read_data}, 32'h0);
    check_eq("reset_data_ready", {31'h0, bus.data_ready}, 32'd0);
    check_eq("reset_rx_valid", {31'h0, bus.rx_valid}, 32'd0);
    check_eq("reset_frame_err", {31'h0, bus.frame_err}, 32'd0);
    check_eq("reset_overrun", {31'h0, bus.overrun}, 32'd0);
    check_eq("reset_busy", {31'h0, bus.busy}, 32'd0);

    // Single byte
    send_frame(8'h55, 1'b1, 1'b1);
    check_eq("b55_valid_count", 32'(n_valid), 32'd1);
    check_eq("b55_data_ready", {31'h0, bus.data_ready}, 32'd1);
    check_eq("b55_read_data", {24'h0, bus.read_data}, 32'h55);
    check_eq("b55_frame_err_count", 32'(n_ferr), 32'd0);
    do_read();
    check_eq("b55_read_clears_ready", {31'h0, bus.data_ready}, 32'd0);

    // Back-to-back frames, each read
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 1'b1, 1'b1);
      check_eq("b2b_data_ready", {31'h0, bus.data_ready}, 32'd1);
      do_read();
      check_eq("b2b_overrun", {31'h0, bus.overrun}, 32'd0);
    end

    // Overrun: two frames without a read, newest wins
    send_frame(8'h9D, 1'b1, 1'b1);
    check_eq("ovr_first_no_overrun", {31'h0, bus.overrun}, 32'd0);
    send_frame(8'h3A, 1'b1, 1'b1);
    check_eq("ovr_overrun_set", {31'h0, bus.overrun}, 32'd1);
    check_eq("ovr_read_data", {24'h0, bus.read_data}, 32'h3A);
    do_read();
    check_eq("ovr_ready_cleared", {31'h0, bus.data_ready}, 32'd0);
    check_eq("ovr_overrun_cleared", {31'h0, bus.overrun}, 32'd0);

    // Short glitch on idle line
    v0 = n_valid;
    f0 = n_ferr;
    @(negedge clk);
    bus.uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    bus.uart_rxd = 1'b1;
    check_eq("glitch_busy_during", {31'h0, bus.busy}, 32'd1);
    repeat (2 * BIT) @(negedge clk);
    check_eq("glitch_busy_after", {31'h0, bus.busy}, 32'd0);
    check_eq("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    check_eq("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);

    // Frame error keeps buffered byte
    send_frame(8'h11, 1'b1, 1'b1);
    f0 = n_ferr;
    v0 = n_valid;
    send_frame(8'h0F, 1'b0, 1'b0);
    check_eq("ferr_pulse_count", 32'(n_ferr - f0), 32'd1);
    check_eq("ferr_no_valid", 32'(n_valid - v0), 32'd0);
    check_eq("ferr_data_ready_kept", {31'h0, bus.data_ready}, 32'd1);
    check_eq("ferr_read_data_kept", {24'h0, bus.read_data}, 32'h11);
    check_eq("ferr_overrun_kept", {31'h0, bus.overrun}, 32'd0);
    do_read();

    // Reset mid-DATA drops the frame; held until the line is idle again
    v0 = n_valid;
    fork
      send_frame(8'h81, 1'b1, 1'b0);
      begin
        repeat (3 * BIT) @(negedge clk);
        check_eq("rstmid_busy_before", {31'h0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_busy_next_clk", {31'h0, bus.busy}, 32'd0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rstmid_no_valid", 32'(n_valid - v0), 32'd0);
    check_eq("rstmid_data_ready", {31'h0, bus.data_ready}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b1);
    check_eq("after_rst_valid", 32'(n_valid - v0), 32'd1);
    check_eq("after_rst_data", {24'h0, bus.read_data}, 32'h7E);
    do_read();

    // Loopback of random bytes
    v0 = n_valid;
    for (int i = 0; i < 200; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b1);
      do_read();
    end
    check_eq("loop_valid_count", 32'(n_valid - v0), 32'd200);
    check_eq("loop_overrun", {31'h0, bus.overrun}, 32'd0);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
